// File: rtl/inst_loader.sv
// Byte-serial program loader: parses SYNC/header/words/checksum frames and
// drives the instruction-memory write port, holding the core until a good load.
module inst_loader #(
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        resetbar,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        im_we,
  output logic [11:0] im_addr,
  output logic [18:0] im_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    IDLE, HDR, WB0, WB1, WB2, WRITE, CHK, DONE, ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  hcnt_q, hcnt_d;
  logic [11:0] addr_q, addr_d;
  logic [11:0] lenm1_q, lenm1_d;
  logic [11:0] wcnt_q, wcnt_d;
  logic [2:0]  whi_q, whi_d;
  logic [7:0]  wmid_q, wmid_d;
  logic [7:0]  xor_q, xor_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [11:0] im_addr_q, im_addr_d;
  logic [18:0] im_wdata_q, im_wdata_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        accept;
  logic        in_frame;
  logic        fail;
  logic [16:0] tnext;
  logic [12:0] last_addr;

  assign in_ready = resetbar && (state_q != WRITE);
  assign accept   = in_valid && in_ready;
  assign im_we    = (state_q == WRITE);
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;

  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    addr_d     = addr_q;
    lenm1_d    = lenm1_q;
    wcnt_d     = wcnt_q;
    whi_d      = whi_q;
    wmid_d     = wmid_q;
    xor_d      = xor_q;
    tcnt_d     = tcnt_q;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    error_d    = error_q;
    fail       = 1'b0;
    tnext      = {1'b0, tcnt_q} + 17'd1;
    last_addr  = {1'b0, addr_q} + {1'b0, lenm1_q[11:8], in_data};
    in_frame   = (state_q == HDR) || (state_q == WB0) || (state_q == WB1) ||
                 (state_q == WB2) || (state_q == CHK);

    // Idle timeout and checksum accumulation apply to every in-frame byte state.
    if (in_frame) begin
      if (accept) begin
        tcnt_d = '0;
        xor_d  = xor_q ^ in_data;
      end else begin
        tcnt_d = tnext[15:0];
        if (tnext >= 17'(TIMEOUT)) fail = 1'b1;
      end
    end

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (accept && (in_data == SYNC)) begin
          state_d    = HDR;
          done_d     = 1'b0;
          error_d    = 1'b0;
          cpu_hold_d = 1'b1;
          xor_d      = '0;
          tcnt_d     = '0;
          hcnt_d     = '0;
        end
      end
      HDR: begin
        if (accept) begin
          hcnt_d = hcnt_q + 2'd1;
          case (hcnt_q)
            2'd0: begin
              if (in_data[7:4] != 4'h0) fail = 1'b1;
              else addr_d[11:8] = in_data[3:0];
            end
            2'd1: addr_d[7:0] = in_data;
            2'd2: begin
              if (in_data[7:4] != 4'h0) fail = 1'b1;
              else lenm1_d[11:8] = in_data[3:0];
            end
            default: begin
              lenm1_d[7:0] = in_data;
              if (last_addr > 13'h0FFF) fail = 1'b1;
              else begin
                state_d = WB0;
                wcnt_d  = '0;
              end
            end
          endcase
        end
      end
      WB0: begin
        if (accept) begin
          if (in_data[7:3] != 5'd0) fail = 1'b1;
          else begin
            whi_d   = in_data[2:0];
            state_d = WB1;
          end
        end
      end
      WB1: begin
        if (accept) begin
          wmid_d  = in_data;
          state_d = WB2;
        end
      end
      WB2: begin
        if (accept) begin
          im_addr_d  = addr_q;
          im_wdata_d = {whi_q, wmid_q, in_data};
          state_d    = WRITE;
        end
      end
      WRITE: begin
        addr_d  = addr_q + 12'd1;
        wcnt_d  = wcnt_q + 12'd1;
        state_d = (wcnt_q == lenm1_q) ? CHK : WB0;
      end
      CHK: begin
        if (accept) begin
          if ((xor_q ^ in_data) == 8'h00) begin
            state_d    = DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            fail = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fail) begin
      state_d    = ERROR;
      error_d    = 1'b1;
      done_d     = 1'b0;
      cpu_hold_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetbar) begin
      state_q    <= IDLE;
      hcnt_q     <= '0;
      addr_q     <= '0;
      lenm1_q    <= '0;
      wcnt_q     <= '0;
      whi_q      <= '0;
      wmid_q     <= '0;
      xor_q      <= '0;
      tcnt_q     <= '0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      addr_q     <= addr_d;
      lenm1_q    <= lenm1_d;
      wcnt_q     <= wcnt_d;
      whi_q      <= whi_d;
      wmid_q     <= wmid_d;
      xor_q      <= xor_d;
      tcnt_q     <= tcnt_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: good/bad frames, header errors, resync,
// idle timeout and mid-frame reset, with a negedge write monitor.
module tb_inst_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        resetbar = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        im_we;
  logic [11:0] im_addr;
  logic [18:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int          tests = 0;
  int          fails = 0;
  int          rdy_viol = 0;
  logic [30:0] wq[$];
  int          wbase;
  int          rbase;

  bq_t good_f = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'h07, 8'hFF, 8'hFF,
                  8'h00, 8'h01, 8'h23, 8'h34};
  bq_t badck_f = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'h07, 8'hFF, 8'hFF,
                   8'h00, 8'h01, 8'h23, 8'h35};

  always #5 clk = ~clk;

  inst_loader #(.SYNC(8'hA5), .TIMEOUT(16)) dut (
    .clk      (clk),
    .resetbar (resetbar),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  // in_ready must be low exactly in the write cycles
  always @(negedge clk) begin
    if (resetbar === 1'b1) begin
      if (im_we === 1'b1) wq.push_back({im_addr, im_wdata});
      if (in_ready === im_we) rdy_viol <= rdy_viol + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int unsigned n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) begin
      fails++;
      $error("FAIL send_timeout observed=in_ready %b expected=1 byte %h", in_ready, b);
    end
    tick();
  endtask

  task automatic send_seq(input bq_t s);
    foreach (s[i]) send(s[i]);
    in_valid = 1'b0;
  endtask

  function automatic logic [30:0] wentry(input int idx);
    if (idx < wq.size()) return wq[idx];
    return '1;
  endfunction

  task automatic start_test();
    wbase = wq.size();
    rbase = rdy_viol;
  endtask

  task automatic check_good(input string tag);
    tick();
    check({tag, "_nwrites"}, 32'(wq.size() - wbase), 32'd2);
    check({tag, "_w0"}, 32'(wentry(wbase)), 32'({12'h010, 19'h7FFFF}));
    check({tag, "_w1"}, 32'(wentry(wbase + 1)), 32'({12'h011, 19'h00123}));
    check({tag, "_rdy"}, 32'(rdy_viol - rbase), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_err"}, 32'(error), 32'd0);
    check({tag, "_addr_hold"}, 32'(im_addr), 32'h011);
    check({tag, "_data_hold"}, 32'(im_wdata), 32'h00123);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick(); tick();
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(im_we), 32'd0);
    check("rst_addr", 32'(im_addr), 32'd0);
    check("rst_wdata", 32'(im_wdata), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    resetbar = 1'b1;
    tick();
    check("idle_ready", 32'(in_ready), 32'd1);

    // Good frame
    start_test();
    send_seq(good_f);
    check_good("good");

    // Bad checksum, then recovery
    start_test();
    send_seq(badck_f);
    tick();
    check("badck_nwrites", 32'(wq.size() - wbase), 32'd2);
    check("badck_err", 32'(error), 32'd1);
    check("badck_done", 32'(done), 32'd0);
    check("badck_hold", 32'(cpu_hold), 32'd1);
    start_test();
    send_seq(good_f);
    check_good("recover");

    // Address range overflow
    start_test();
    send(8'hA5); send(8'h0F); send(8'hFF); send(8'h00);
    check("range_pre_err", 32'(error), 32'd0);
    send(8'h01);
    in_valid = 1'b0;
    check("range_err", 32'(error), 32'd1);
    check("range_hold", 32'(cpu_hold), 32'd1);
    tick(); tick();
    check("range_nwrites", 32'(wq.size() - wbase), 32'd0);

    // Bad word high byte
    start_test();
    send(8'hA5); send(8'h00); send(8'h10); send(8'h00); send(8'h00);
    check("wb0_pre_err", 32'(error), 32'd0);
    send(8'h08);
    in_valid = 1'b0;
    check("wb0_err", 32'(error), 32'd1);
    tick(); tick();
    check("wb0_nwrites", 32'(wq.size() - wbase), 32'd0);

    // Bad H0 nibble
    send(8'hA5);
    check("h0_pre_err", 32'(error), 32'd0);
    send(8'h10);
    in_valid = 1'b0;
    check("h0_err", 32'(error), 32'd1);

    // Garbage then resync
    send(8'h3C); send(8'h00); send(8'hFF);
    in_valid = 1'b0;
    check("garbage_err", 32'(error), 32'd1);
    check("garbage_done", 32'(done), 32'd0);
    start_test();
    send_seq(good_f);
    check_good("resync");

    // Idle timeout
    send(8'hA5); send(8'h00); send(8'h10);
    in_valid = 1'b0;
    repeat (15) tick();
    check("tmo_15_err", 32'(error), 32'd0);
    send(8'h00);
    in_valid = 1'b0;
    repeat (15) tick();
    check("tmo_15b_err", 32'(error), 32'd0);
    tick();
    check("tmo_16_err", 32'(error), 32'd1);
    check("tmo_16_hold", 32'(cpu_hold), 32'd1);

    // Reset mid-frame
    send(8'hA5); send(8'h00); send(8'h10); send(8'h00); send(8'h00);
    send(8'h01); send(8'h23);
    in_valid = 1'b0;
    resetbar = 1'b0;
    tick();
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_we", 32'(im_we), 32'd0);
    check("mid_rst_addr", 32'(im_addr), 32'd0);
    check("mid_rst_wdata", 32'(im_wdata), 32'd0);
    check("mid_rst_hold", 32'(cpu_hold), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_err", 32'(error), 32'd0);
    resetbar = 1'b1;
    tick();
    start_test();
    send_seq(good_f);
    check_good("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
